// File: rtl/store_drain_buffer.sv
// Store queue that drains into a word-only data memory write port.
// Byte and halfword stores are completed as read-modify-write of the addressed word.
module store_drain_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [31:0]      st_addr,
  input  logic [31:0]      st_data,
  input  logic [1:0]       st_type,
  input  logic [31:0]      st_pc,
  output logic             dm_MW,
  output logic [31:0]      dm_WA,
  output logic [31:0]      dm_WD,
  output logic [31:0]      dm_WPC,
  input  logic [31:0]      dm_MD,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [1:0] TYPE_BYTE = 2'd1;
  localparam logic [1:0] TYPE_HALF = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  typ;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  entry_t           mem [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  state_t           state;
  logic [31:0]      merged_q;
  logic [31:0]      merged_c;
  logic             push;
  logic             pop;
  logic             head_is_rmw;

  assign head        = mem[rd_ptr];
  assign st_ready    = (count_q < CNT_W'(DEPTH));
  assign push        = st_valid && st_ready;
  assign pop         = (state == WR);
  assign head_is_rmw = (head.typ == TYPE_BYTE) || (head.typ == TYPE_HALF);
  assign empty       = (count_q == '0) && (state == IDLE);
  assign count       = count_q;

  // Entry storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{addr: st_addr, data: st_data, typ: st_type, pc: st_pc};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Drain sequencer; merged word is captured from memory at the end of RD.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      merged_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count_q != '0) state <= head_is_rmw ? RD : WR;
        end
        RD: begin
          merged_q <= merged_c;
          state    <= WR;
        end
        WR:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Insert the head's byte/half into the word currently read from memory.
  always_comb begin
    merged_c = dm_MD;
    if (head.typ == TYPE_BYTE) begin
      case (head.addr[1:0])
        2'd0:    merged_c[7:0]   = head.data[7:0];
        2'd1:    merged_c[15:8]  = head.data[7:0];
        2'd2:    merged_c[23:16] = head.data[7:0];
        default: merged_c[31:24] = head.data[7:0];
      endcase
    end else if (head.typ == TYPE_HALF) begin
      if (head.addr[1]) merged_c[31:16] = head.data[15:0];
      else              merged_c[15:0]  = head.data[15:0];
    end
  end

  // Memory port is decoded from registered state only, so reset kills a write at once.
  always_comb begin
    dm_MW  = 1'b0;
    dm_WA  = '0;
    dm_WD  = '0;
    dm_WPC = '0;
    case (state)
      RD: begin
        dm_WA  = {head.addr[31:2], 2'b00};
        dm_WPC = head.pc;
      end
      WR: begin
        dm_MW  = 1'b1;
        dm_WA  = {head.addr[31:2], 2'b00};
        dm_WPC = head.pc;
        dm_WD  = head_is_rmw ? merged_q : head.data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_store_drain_buffer.sv
// Directed bench for store_drain_buffer with a word-addressed memory model and write log.
module tb_store_drain_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_type;
  logic [31:0] st_pc;
  logic        dm_MW;
  logic [31:0] dm_WA;
  logic [31:0] dm_WD;
  logic [31:0] dm_WPC;
  logic [31:0] dm_MD;
  logic        empty;
  logic [2:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] tbmem [64];
  logic        mem_clr;
  logic [31:0] log_a   [64];
  logic [31:0] log_d   [64];
  logic [31:0] log_pc  [64];
  int          wr_n = 0;

  store_drain_buffer #(.DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_type(st_type), .st_pc(st_pc),
    .dm_MW(dm_MW), .dm_WA(dm_WA), .dm_WD(dm_WD), .dm_WPC(dm_WPC),
    .dm_MD(dm_MD), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_MD = tbmem[dm_WA[7:2]];

  // Memory model and write trace.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tbmem[i] <= 32'h0;
    end else if (dm_MW) begin
      tbmem[dm_WA[7:2]] <= dm_WD;
      log_a[wr_n]  <= dm_WA;
      log_d[wr_n]  <= dm_WD;
      log_pc[wr_n] <= dm_WPC;
      wr_n         <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] t, input logic [31:0] pc);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_type  = t;
    st_pc    = pc;
  endtask

  task automatic wait_writes(input int n);
    for (int c = 0; c < 60 && wr_n < n; c++) tick();
    check("write_count", 32'(wr_n), 32'(n));
  endtask

  task automatic chk_wr(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] pc);
    check($sformatf("wr%0d_addr", k), log_a[k], a);
    check($sformatf("wr%0d_data", k), log_d[k], d);
    check($sformatf("wr%0d_pc", k), log_pc[k], pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int idx;
    int wn;
    logic acc;
    logic full_seen;

    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    reset   = 1'b0;
    mem_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b1;
    mem_clr = 1'b0;

    check("rst_empty", 32'(empty), 32'd1);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_mw", 32'(dm_MW), 32'd0);
    check("rst_wa", dm_WA, 32'h0);
    check("rst_wd", dm_WD, 32'h0);
    check("rst_wpc", dm_WPC, 32'h0);

    // Word store: write in the 2nd cycle after the push edge.
    drive(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 32'h3000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("w_c1_count", 32'(count), 32'd1);
    check("w_c1_mw", 32'(dm_MW), 32'd0);
    check("w_c1_empty", 32'(empty), 32'd0);
    tick();
    check("w_c2_mw", 32'(dm_MW), 32'd1);
    check("w_c2_wa", dm_WA, 32'h10);
    check("w_c2_wd", dm_WD, 32'hDEADBEEF);
    check("w_c2_wpc", dm_WPC, 32'h3000);
    tick();
    check("w_c3_mw", 32'(dm_MW), 32'd0);
    check("w_c3_empty", 32'(empty), 32'd1);
    check("w_c3_count", 32'(count), 32'd0);
    wait_writes(1);
    chk_wr(0, 32'h10, 32'hDEADBEEF, 32'h3000);

    // Byte store as read-modify-write.
    drive(1'b1, 32'h10, 32'h11223344, 2'd0, 32'h3004);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    wait_writes(2);
    drive(1'b1, 32'h12, 32'h123456AB, 2'd1, 32'h3008);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("b_c1_mw", 32'(dm_MW), 32'd0);
    check("b_c1_wa", dm_WA, 32'h0);
    tick();
    check("b_c2_mw", 32'(dm_MW), 32'd0);
    check("b_c2_wa", dm_WA, 32'h10);
    tick();
    check("b_c3_mw", 32'(dm_MW), 32'd1);
    check("b_c3_wd", dm_WD, 32'h11AB3344);
    check("b_c3_wpc", dm_WPC, 32'h3008);
    tick();
    check("b_c4_empty", 32'(empty), 32'd1);
    wait_writes(3);

    // Two halfword stores to the same word, back to back.
    drive(1'b1, 32'h10, 32'h11223344, 2'd0, 32'h300C);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    wait_writes(4);
    drive(1'b1, 32'h12, 32'hFFFFCAFE, 2'd2, 32'h3010);
    tick();
    drive(1'b1, 32'h11, 32'h12345566, 2'd2, 32'h3014);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    wait_writes(6);
    chk_wr(4, 32'h10, 32'hCAFE3344, 32'h3010);
    chk_wr(5, 32'h10, 32'hCAFE5566, 32'h3014);

    // Back-pressure: six byte stores with st_valid held high.
    idx = 0;
    full_seen = 1'b0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      drive(1'b1, 32'h40 + 32'(4 * idx) + 32'(idx & 3), 32'hB0 + 32'(idx), 2'd1,
            32'h5000 + 32'(4 * idx));
      acc = st_ready;
      if (!st_ready && !full_seen) begin
        full_seen = 1'b1;
        check("full_accepted", 32'(idx), 32'd5);
        check("full_count", 32'(count), 32'd4);
      end
      tick();
      if (acc) idx++;
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("bp_full_seen", 32'(full_seen), 32'd1);
    check("bp_pushed", 32'(idx), 32'd6);
    wait_writes(12);
    chk_wr(6,  32'h40, 32'h000000B0, 32'h5000);
    chk_wr(7,  32'h44, 32'h0000B100, 32'h5004);
    chk_wr(8,  32'h48, 32'h00B20000, 32'h5008);
    chk_wr(9,  32'h4C, 32'hB3000000, 32'h500C);
    chk_wr(10, 32'h50, 32'h000000B4, 32'h5010);
    chk_wr(11, 32'h54, 32'h0000B500, 32'h5014);
    check("bp_count_end", 32'(count), 32'd0);

    // Push on the WR edge with two queued, then wrap the pointers.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h80 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 2'd0, 32'h6000 + 32'(4 * i));
      check($sformatf("pp%0d_ready", i), 32'(st_ready), 32'd1);
      if (i == 2) begin
        check("pp_pre_mw", 32'(dm_MW), 32'd1);
        check("pp_pre_count", 32'(count), 32'd2);
      end
      tick();
      if (i == 2) begin
        check("pp_post_count", 32'(count), 32'd2);
        check("pp_post_mw", 32'(dm_MW), 32'd0);
      end
    end
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    wait_writes(17);
    for (int i = 0; i < 5; i++)
      chk_wr(12 + i, 32'h80 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 32'h6000 + 32'(4 * i));

    // Reset during the WR of a byte store with three entries queued.
    drive(1'b1, 32'h94, 32'h000000EE, 2'd1, 32'h8000);
    tick();
    drive(1'b1, 32'h98, 32'h98989898, 2'd0, 32'h8004);
    tick();
    drive(1'b1, 32'h9C, 32'h9C9C9C9C, 2'd0, 32'h8008);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("rmw_pre_mw", 32'(dm_MW), 32'd1);
    check("rmw_pre_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check("rmw_rst_mw", 32'(dm_MW), 32'd0);
    check("rmw_rst_wa", dm_WA, 32'h0);
    check("rmw_rst_count", 32'(count), 32'd0);
    check("rmw_rst_empty", 32'(empty), 32'd1);
    check("rmw_rst_ready", 32'(st_ready), 32'd1);
    wn = wr_n;
    tick();
    check("rmw_no_write", 32'(wr_n), 32'd17);
    check("rmw_no_write_delta", 32'(wr_n - wn), 32'd0);
    reset = 1'b1;
    drive(1'b1, 32'h90, 32'h0BADF00D, 2'd0, 32'h7000);
    tick();
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0);
    check("post_c1_mw", 32'(dm_MW), 32'd0);
    check("post_c1_count", 32'(count), 32'd1);
    tick();
    check("post_c2_mw", 32'(dm_MW), 32'd1);
    check("post_c2_wa", dm_WA, 32'h90);
    check("post_c2_wd", dm_WD, 32'h0BADF00D);
    wait_writes(18);
    chk_wr(17, 32'h90, 32'h0BADF00D, 32'h7000);
    tick();
    check("post_empty", 32'(empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
